bch_encode_serial: RTL and testbench
====================================

# bch_encode_serial

Bit-serial systematic BCH encoder, the transmit-side counterpart of the BCH decode chain (syndrome, error-locator, Chien search). It accepts K message bits one per handshake, passes them through unchanged, and then appends P parity bits: the remainder of x^P·m(x) mod g(x), where g(x) is the code's generator polynomial. It sits between the data source and the channel or storage write path. Its output is a full codeword stream framed with first and last flags.

## Interface
Parameters:
- M, 4: GF(2^M) field order; code length N = 2^M−1.
- T, 3: correctable errors. g(x) and P = deg g(x) are computed at elaboration from the shared BCH parameter functions.
- K, N−P: message bits per codeword. 1 ≤ K ≤ N−P; K < N−P gives a shortened code.

Ports:
- clk, in, 1: single clock.
- reset, in, 1: synchronous, active-high.
- in_bit, in, 1: message bit. The first bit is the coefficient of x^(K−1).
- in_valid, in, 1: in_bit is valid.
- in_ready, out, 1: encoder accepts in_bit this cycle.
- out_bit, out, 1: codeword bit (registered).
- out_valid, out, 1: out_bit is valid.
- out_ready, in, 1: downstream accepts out_bit.
- out_first, out, 1: out_bit is codeword bit 0 (first message bit).
- out_last, out, 1: out_bit is the final parity bit.

## Operation
- State is {DATA, PARITY}, with a counter cnt of ceil(log2(max(K,P))) bits, a remainder register r[P−1:0], and an output register.
- The output register is "free" when !out_valid || out_ready.
- **DATA state:**
  - in_ready = free.
  - On in_valid && in_ready:
    - out_bit ← in_bit; out_valid ← 1; out_first ← (cnt==0); out_last ← 0.
    - fb = in_bit ^ r[P−1]; r ← {r[P−2:0],0} ^ (fb ? g[P−1:0] : 0).
    - cnt ← cnt+1.
  - When cnt==K−1 is accepted: cnt ← 0 and state → PARITY.
- **PARITY state:**
  - in_ready = 0.
  - When free:
    - out_bit ← r[P−1]; out_valid ← 1; out_first ← 0; out_last ← (cnt==P−1).
    - r ← {r[P−2:0],0}; cnt ← cnt+1.
  - When cnt==P−1 is loaded: r ← 0, cnt ← 0, state → DATA.
- **Idle output:** if free and nothing is loaded, out_valid ← 0.
- **Stalls:** out_bit, out_first and out_last hold stable while out_valid && !out_ready.
- **Framing:** in_valid is ignored while in_ready=0, so message bits arriving during PARITY stall upstream. Each codeword is exactly K+P output transfers.
- **Reset:**
  - Outputs go to out_valid=0, out_bit=0, out_first=0, out_last=0.
  - in_ready=1 on the first cycle after reset (state DATA, output register free).
  - Internal state goes to state=DATA, cnt=0, r=0.
  - A reset mid-codeword discards the partial codeword. The next accepted bit is message bit 0.

## Timing
- Latency: one cycle from input acceptance to out_valid for that bit.
- Throughput: one bit per cycle with out_ready held high, i.e. N−(N−P−K) = K+P cycles per codeword with no bubble.
  - The first parity bit is presented in the cycle after the last message bit.
  - Message bit 0 of the next codeword can be accepted in the cycle after the last parity bit is loaded, so it appears on out_bit immediately after out_last.
- Backpressure: in_ready combinationally follows out_ready in DATA state. No other combinational input-to-output paths exist.
- Simultaneous events: in PARITY, a load on the same cycle as the downstream accept of the previous bit is permitted. In DATA, in_valid=0 with the register being drained leaves out_valid=0 the next cycle.

## Test plan
- M=4, T=1 (g=x^4+x+1, P=4, K=11), message 1 followed by ten 0s → out 1,0×10, then parity 1,0,0,1. out_first on bit 0; out_last on bit 14 only.
- M=4, T=1, message ten 0s then 1 → parity 0,0,1,1. All-zero message → parity 0,0,0,0.
- M=4, T=3 (g=0x537, P=10, K=5), message 0,0,0,0,1 → parity 0,1,0,0,1,1,0,1,1,1.
- Random out_ready backpressure (≈50%) over 1000 random codewords (T=2, g=0x1D1, K=7):
  - Every output codeword is divisible by g(x).
  - The data bits match the input.
  - out_bit is stable under stall, and in_ready=0 for the P cycles of PARITY.
- Back-to-back codewords with in_valid and out_ready held high → 15-cycle period, no gaps, out_first immediately follows out_last.
- Assert reset after the 3rd message bit, then send a full message → output matches a clean encode. out_valid=0 and in_ready=1 on the cycle after reset.

Source files
------------

// File: rtl/bch_encode_serial.sv
// Bit-serial systematic BCH encoder: message bits pass straight through, then the
// P parity bits (x^P*m(x) mod g(x)) follow, MSB first, framed by first/last flags.

package bch_pkg;

    localparam int BCH_MAX_M = 10;

    function automatic logic [BCH_MAX_M:0] bch_prim_poly(input int m);
        case (m)
            3:       return 11'h00B;
            4:       return 11'h013;
            5:       return 11'h025;
            6:       return 11'h043;
            7:       return 11'h089;
            8:       return 11'h11D;
            9:       return 11'h211;
            10:      return 11'h409;
            default: return 11'h013;
        endcase
    endfunction

    function automatic logic [BCH_MAX_M-1:0] gf_mul(input logic [BCH_MAX_M-1:0] a,
                                                    input logic [BCH_MAX_M-1:0] b,
                                                    input int m);
        logic [BCH_MAX_M:0] acc;
        logic [BCH_MAX_M:0] prim;
        acc  = '0;
        prim = bch_prim_poly(m);
        for (int i = BCH_MAX_M - 1; i >= 0; i--) begin
            if (i < m) begin
                acc = acc << 1;
                if (acc[m]) begin
                    acc = acc ^ prim;
                end
                if (b[i]) begin
                    acc = acc ^ {1'b0, a};
                end
            end
        end
        return acc[BCH_MAX_M-1:0];
    endfunction

    function automatic logic [BCH_MAX_M-1:0] gf_alpha_pow(input int e, input int m);
        logic [BCH_MAX_M-1:0] r;
        r = {{(BCH_MAX_M-1){1'b0}}, 1'b1};
        for (int i = 0; i < e; i++) begin
            r = gf_mul(r, {{(BCH_MAX_M-2){1'b0}}, 2'b10}, m);
        end
        return r;
    endfunction

    // g(x) = product of the distinct minimal polynomials of alpha^1, alpha^3, ..., alpha^(2T-1)
    function automatic logic [63:0] bch_gen_poly(input int m, input int t);
        logic [63:0]                          g;
        logic [63:0]                          prod;
        logic [1023:0]                        covered;
        logic [BCH_MAX_M*(BCH_MAX_M+1)-1:0]   c;
        logic [BCH_MAX_M-1:0]                 a;
        logic [BCH_MAX_M-1:0]                 lo;
        int                                   n;
        int                                   e;
        int                                   deg;
        n       = (32'sd1 << m) - 32'sd1;
        g       = 64'd1;
        covered = '0;
        for (int i = 1; i <= 2 * t - 1; i += 2) begin
            if (!covered[i]) begin
                c    = '0;
                c[0] = 1'b1;
                deg  = 0;
                e    = i;
                for (int s = 0; s < m; s++) begin
                    if (!covered[e]) begin
                        covered[e] = 1'b1;
                        a = gf_alpha_pow(e, m);
                        for (int k = deg + 1; k >= 0; k--) begin
                            lo = (k > 0) ? c[(k-1)*BCH_MAX_M +: BCH_MAX_M] : '0;
                            c[k*BCH_MAX_M +: BCH_MAX_M] = lo ^ gf_mul(c[k*BCH_MAX_M +: BCH_MAX_M], a, m);
                        end
                        deg++;
                    end
                    e = (e * 2) % n;
                end
                prod = '0;
                for (int k = 0; k <= deg; k++) begin
                    if (c[k*BCH_MAX_M]) begin
                        prod = prod ^ (g << k);
                    end
                end
                g = prod;
            end
        end
        return g;
    endfunction

    function automatic int bch_deg(input logic [63:0] p);
        for (int i = 63; i >= 0; i--) begin
            if (p[i]) begin
                return i;
            end
        end
        return 0;
    endfunction

    function automatic int bch_n(input int m);
        return (32'sd1 << m) - 32'sd1;
    endfunction

    function automatic int bch_p(input int m, input int t);
        return bch_deg(bch_gen_poly(m, t));
    endfunction

endpackage

module bch_encode_serial
    import bch_pkg::*;
#(
    parameter int M = 4,
    parameter int T = 3,
    parameter int K = bch_n(M) - bch_p(M, T)
) (
    input  logic clk,
    input  logic reset,
    input  logic in_bit,
    input  logic in_valid,
    output logic in_ready,
    output logic out_bit,
    output logic out_valid,
    input  logic out_ready,
    output logic out_first,
    output logic out_last
);

    localparam logic [63:0] G_FULL  = bch_gen_poly(M, T);
    localparam int          P       = bch_deg(G_FULL);
    localparam logic [P-1:0] G_LOW  = G_FULL[P-1:0];
    localparam int          CNT_MAX = (K > P) ? K : P;
    localparam int          CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_K_LAST = CNT_W'(K - 1);
    localparam logic [CNT_W-1:0] CNT_P_LAST = CNT_W'(P - 1);

    typedef enum logic [0:0] {
        ST_DATA   = 1'b0,
        ST_PARITY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [P-1:0]     r_q, r_d;
    logic             out_bit_q, out_bit_d;
    logic             out_valid_q, out_valid_d;
    logic             out_first_q, out_first_d;
    logic             out_last_q, out_last_d;
    logic             free_s;
    logic             fb_s;
    logic             in_ready_s;

    assign free_s    = !out_valid_q || out_ready;
    assign fb_s      = in_bit ^ r_q[P-1];
    assign in_ready  = in_ready_s;
    assign out_bit   = out_bit_q;
    assign out_valid = out_valid_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;

    // Next-state: pass message bits while dividing, then shift the remainder out
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        r_d         = r_q;
        out_bit_d   = out_bit_q;
        out_valid_d = out_valid_q;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;
        in_ready_s  = 1'b0;
        case (state_q)
            ST_DATA: begin
                in_ready_s = free_s;
                if (in_valid && free_s) begin
                    out_bit_d   = in_bit;
                    out_valid_d = 1'b1;
                    out_first_d = (cnt_q == {CNT_W{1'b0}});
                    out_last_d  = 1'b0;
                    r_d         = {r_q[P-2:0], 1'b0} ^ (fb_s ? G_LOW : {P{1'b0}});
                    if (cnt_q == CNT_K_LAST) begin
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = ST_PARITY;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end else if (free_s) begin
                    out_valid_d = 1'b0;
                end else begin
                    out_valid_d = out_valid_q;
                end
            end
            ST_PARITY: begin
                if (free_s) begin
                    out_bit_d   = r_q[P-1];
                    out_valid_d = 1'b1;
                    out_first_d = 1'b0;
                    out_last_d  = (cnt_q == CNT_P_LAST);
                    if (cnt_q == CNT_P_LAST) begin
                        r_d     = {P{1'b0}};
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = ST_DATA;
                    end else begin
                        r_d     = {r_q[P-2:0], 1'b0};
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_DATA;
            end
        endcase
    end

    // State, remainder and output register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_DATA;
            cnt_q       <= {CNT_W{1'b0}};
            r_q         <= {P{1'b0}};
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            r_q         <= r_d;
            out_bit_q   <= out_bit_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule

// File: tb/tb_bch_encode_serial.sv
// Scoreboard bench for bch_encode_serial: three code configurations run side by side,
// each with a cycle model of the handshake and a queue of expected codeword bits.

module tb_bch_encode_serial;

    localparam int NI = 3;
    localparam int TS[NI] = '{1, 3, 2};
    localparam int KS[NI] = '{11, 5, 7};
    localparam int PS[NI] = '{4, 10, 8};
    localparam logic [31:0] GS[NI] = '{32'h13, 32'h537, 32'h1D1};
    localparam bit RND[NI] = '{1'b0, 1'b0, 1'b1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_s[NI];
    logic in_bit_s[NI];
    logic in_valid_s[NI];
    logic in_ready_s[NI];
    logic out_bit_s[NI];
    logic out_valid_s[NI];
    logic out_ready_s[NI];
    logic out_first_s[NI];
    logic out_last_s[NI];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;
    int wd_s[NI];
    int fc_s[NI];
    int pf_s[NI];
    logic [31:0] lp_s[NI];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Remainder of polynomial v (len coefficients, MSB = highest power) divided by g of degree p
    function automatic logic [31:0] poly_mod(input logic [31:0] v, input int len,
                                             input logic [31:0] g, input int p);
        logic [31:0] r;
        r = v;
        for (int b = len - 1; b >= p; b--) begin
            if (r[b]) r = r ^ (g << (b - p));
        end
        return r;
    endfunction

    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
        localparam int KK = KS[gi];
        localparam int PP = PS[gi];
        localparam logic [31:0] GG = GS[gi];

        bch_encode_serial #(.M(4), .T(TS[gi]), .K(KK)) u_dut (
            .clk       (clk),
            .reset     (reset_s[gi]),
            .in_bit    (in_bit_s[gi]),
            .in_valid  (in_valid_s[gi]),
            .in_ready  (in_ready_s[gi]),
            .out_bit   (out_bit_s[gi]),
            .out_valid (out_valid_s[gi]),
            .out_ready (out_ready_s[gi]),
            .out_first (out_first_s[gi]),
            .out_last  (out_last_s[gi])
        );

        logic [2:0] sb_q[$];
        int words_done = 0;
        int first_cyc = 0;
        int prev_first = 0;
        logic [31:0] last_par = '0;

        assign wd_s[gi] = words_done;
        assign fc_s[gi] = first_cyc;
        assign pf_s[gi] = prev_first;
        assign lp_s[gi] = last_par;

        initial begin : model
            bit ov_m;
            bit in_data;
            bit just_rst;
            bit free_m;
            bit load;
            int acc;
            int par;
            logic [31:0] msg;
            logic [31:0] cw;
            logic [31:0] pv;
            logic [2:0] hd;
            ov_m = 1'b0; in_data = 1'b1; just_rst = 1'b0;
            acc = 0; par = 0; msg = '0; cw = '0;
            forever begin
                @(negedge clk);
                if (reset_s[gi]) begin
                    ov_m = 1'b0; in_data = 1'b1; acc = 0; par = 0;
                    msg = '0; cw = '0; sb_q.delete(); just_rst = 1'b1;
                end else begin
                    free_m = !ov_m || out_ready_s[gi];
                    check_eq("out_valid", 32'(out_valid_s[gi]), 32'(ov_m));
                    check_eq("in_ready", 32'(in_ready_s[gi]), 32'(in_data && free_m));
                    if (just_rst) begin
                        check_eq("reset_outs", 32'({out_bit_s[gi], out_first_s[gi], out_last_s[gi]}), 32'd0);
                        just_rst = 1'b0;
                    end
                    if (ov_m) begin
                        check_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                        if (sb_q.size() != 0) begin
                            hd = sb_q[0];
                            check_eq("bit_first_last", 32'({out_bit_s[gi], out_first_s[gi], out_last_s[gi]}), 32'(hd));
                            if (out_ready_s[gi]) begin
                                void'(sb_q.pop_front());
                                cw = {cw[30:0], out_bit_s[gi]};
                                if (hd[1]) begin
                                    prev_first = first_cyc;
                                    first_cyc  = cyc;
                                end
                                if (hd[0]) begin
                                    check_eq("cw_divisible", poly_mod(cw, KK + PP, GG, PP), 32'd0);
                                    last_par = cw & ((32'd1 << PP) - 32'd1);
                                    words_done++;
                                    cw = '0;
                                end
                            end
                        end
                    end
                    if (in_data) begin
                        load = in_valid_s[gi] && free_m;
                        if (load) begin
                            sb_q.push_back({in_bit_s[gi], acc == 0, 1'b0});
                            msg = {msg[30:0], in_bit_s[gi]};
                            acc++;
                            if (acc == KK) begin
                                in_data = 1'b0;
                                par = 0;
                                pv = poly_mod(msg << PP, KK + PP, GG, PP);
                                for (int j = PP - 1; j >= 0; j--) begin
                                    sb_q.push_back({pv[j], 1'b0, j == 0});
                                end
                            end
                        end
                    end else begin
                        load = free_m;
                        if (load) begin
                            par++;
                            if (par == PP) begin
                                in_data = 1'b1;
                                acc = 0;
                                msg = '0;
                            end
                        end
                    end
                    ov_m = load ? 1'b1 : (free_m ? 1'b0 : ov_m);
                end
            end
        end
    end

    initial begin : ready_drv
        for (int i = 0; i < NI; i++) out_ready_s[i] = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NI; i++) begin
                out_ready_s[i] = RND[i] ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    task automatic send_msg(input int idx, input logic [15:0] msg, input int k,
                            input bit gaps, input bit hold);
        bit taken;
        for (int j = k - 1; j >= 0; j--) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    in_valid_s[idx] = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            in_bit_s[idx]   = msg[j];
            in_valid_s[idx] = 1'b1;
            taken = 1'b0;
            for (int w = 0; w < 200 && !taken; w++) begin
                @(negedge clk);
                taken = in_ready_s[idx];
                @(posedge clk);
                #1;
            end
            check_eq("accept_in_time", 32'(taken), 32'd1);
        end
        if (!hold) in_valid_s[idx] = 1'b0;
    endtask

    task automatic wait_words(input int idx, input int n, input int budget);
        for (int w = 0; w < budget && wd_s[idx] < n; w++) begin
            @(posedge clk);
            #1;
        end
        check_eq("words_done", 32'(wd_s[idx]), 32'(n));
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            reset_s[i] = 1'b1;
            in_valid_s[i] = 1'b0;
            in_bit_s[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) reset_s[i] = 1'b0;

        fork
            begin
                send_msg(0, 16'h0400, 11, 1'b0, 1'b0);
                wait_words(0, 1, 200);
                check_eq("par_t1_first1", lp_s[0], 32'h9);
                send_msg(0, 16'h0001, 11, 1'b0, 1'b0);
                wait_words(0, 2, 200);
                check_eq("par_t1_last1", lp_s[0], 32'h3);
                send_msg(0, 16'h0000, 11, 1'b0, 1'b0);
                wait_words(0, 3, 200);
                check_eq("par_t1_zero", lp_s[0], 32'h0);
                send_msg(0, 16'h05A3, 11, 1'b0, 1'b1);
                send_msg(0, 16'h02C7, 11, 1'b0, 1'b0);
                wait_words(0, 5, 200);
                check_eq("b2b_period", 32'(fc_s[0] - pf_s[0]), 32'd15);
                send_msg(0, 16'h0005, 3, 1'b0, 1'b0);
                reset_s[0] = 1'b1;
                @(posedge clk);
                #1;
                reset_s[0] = 1'b0;
                send_msg(0, 16'h06B1, 11, 1'b0, 1'b0);
                wait_words(0, 6, 200);
                check_eq("par_after_reset", lp_s[0], poly_mod(32'h06B1 << 4, 15, 32'h13, 4));
            end
            begin
                send_msg(1, 16'h0001, 5, 1'b0, 1'b0);
                wait_words(1, 1, 200);
                check_eq("par_t3_one", lp_s[1], 32'h137);
                send_msg(1, 16'h0016, 5, 1'b1, 1'b0);
                send_msg(1, 16'h001F, 5, 1'b1, 1'b0);
                wait_words(1, 3, 200);
            end
            begin
                for (int w = 0; w < 1000; w++) begin
                    send_msg(2, 16'($urandom_range(0, 127)), 7, 1'b1, 1'b0);
                end
                wait_words(2, 1000, 2000);
            end
        join

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
